// File: rtl/lcd_hd44780_ctrl.sv
`timescale 1ns/1ps
// lcd_hd44780_ctrl: buffers LCD command words written by the core and replays
// each one to an HD44780-style LCD with setup / enable / hold / execute timing.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_lcd_wr, i_lcd_wdata     one-cycle write strobe and command word
//                             ([7:0] data, [8] RS, [9] long wait, [31] power)
//   i_ovf_clr                 clears the sticky overflow flag
//   o_lcd_data/rs/rw/en/on    LCD pins (rw tied low, write only)
//   o_busy, o_full, o_ovf     status for core polling
module lcd_hd44780_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_PULSE     = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_WAIT      = 2000,
  parameter int unsigned T_WAIT_LONG = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lcd_wr,
  input  logic [31:0] i_lcd_wdata,
  input  logic        i_ovf_clr,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_full,
  output logic        o_ovf
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned T_MAX0 = (T_WAIT_LONG > T_WAIT) ? T_WAIT_LONG : T_WAIT;
  localparam int unsigned T_MAX1 = (T_PULSE > T_MAX0) ? T_PULSE : T_MAX0;
  localparam int unsigned T_MAX2 = (T_SETUP > T_MAX1) ? T_SETUP : T_MAX1;
  localparam int unsigned T_MAX  = (T_HOLD > T_MAX2) ? T_HOLD : T_MAX2;
  localparam int unsigned CNT_W  = $clog2(T_MAX + 1);

  typedef struct packed {
    logic       on;
    logic       long_wait;
    logic       rs;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               rs_q, rs_d;
  logic               on_q, on_d;
  logic               long_q, long_d;
  logic               en_q, en_d;
  logic               ovf_q, ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  cmd_t               mem_q [FIFO_DEPTH];
  cmd_t               mem_d [FIFO_DEPTH];

  cmd_t               cmd_in;
  cmd_t               head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_ok;
  logic               wr_drop;
  logic               cnt_last;
  logic               pop;
  logic               unused_wdata;

  assign cmd_in       = {i_lcd_wdata[31], i_lcd_wdata[9], i_lcd_wdata[8], i_lcd_wdata[7:0]};
  assign unused_wdata = ^i_lcd_wdata[30:10];
  assign head         = mem_q[rd_ptr_q];
  assign fifo_full    = (lvl_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty   = (lvl_q == '0);
  assign wr_ok        = i_lcd_wr && !fifo_full;
  assign wr_drop      = i_lcd_wr && fifo_full;
  assign cnt_last     = (cnt_q == CNT_W'(1));

  // Sequencer: each phase loads the counter and leaves when it reaches 1.
  // The end of WAIT pops the next word directly so queued commands chain
  // with no idle cycle between them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    on_d    = on_q;
    long_d  = long_q;
    en_d    = en_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      S_SETUP: begin
        if (cnt_last) begin
          state_d = S_PULSE;
          cnt_d   = CNT_W'(T_PULSE);
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_last) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(T_HOLD);
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_last) begin
          state_d = S_WAIT;
          cnt_d   = long_q ? CNT_W'(T_WAIT_LONG) : CNT_W'(T_WAIT);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!fifo_empty) pop = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        en_d    = 1'b0;
      end
    endcase

    if (pop) begin
      state_d = S_SETUP;
      cnt_d   = CNT_W'(T_SETUP);
      data_d  = head.data;
      rs_d    = head.rs;
      on_d    = head.on;
      long_d  = head.long_wait;
      en_d    = 1'b0;
    end
  end

  // Command FIFO; a write into a full FIFO is dropped even if a pop happens
  // on the same edge, and flags overflow (set beats clear).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    ovf_d    = ovf_q;

    if (wr_ok) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({wr_ok, pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase

    if (wr_drop)        ovf_d = 1'b1;
    else if (i_ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      on_q     <= 1'b0;
      long_q   <= 1'b0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      on_q     <= on_d;
      long_q   <= long_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      mem_q    <= mem_d;
    end
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;
  assign o_ovf      = ovf_q;
  assign o_busy     = (state_q != S_IDLE) || !fifo_empty;
  assign o_full     = fifo_full;

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Downstream consumer of the single-cycle core's LCD IO register.
- The core's LSU issues a one-cycle write strobe with a 32-bit LCD command word.
- This block buffers command words in a small FIFO and replays each one to an HD44780-style character LCD with correct setup, enable-pulse, hold and execution-wait timing.
- It reports busy and overflow status back to the core for polling.

Parameters:
- FIFO_DEPTH, 4: command words buffered; power of two, at least 2.
- T_SETUP, 2: cycles RS/DATA are stable before EN rises.
- T_PULSE, 12: cycles EN is held high.
- T_HOLD, 2: cycles RS/DATA are held after EN falls.
- T_WAIT, 2000: execution wait after a normal command (40 us at 50 MHz).
- T_WAIT_LONG, 82000: execution wait when the long flag is set (clear/home, 1.64 ms).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_lcd_wr  in  1  one-cycle write strobe from the LSU IO decode.
- i_lcd_wdata  in  32  command word.
  - [7:0] data byte.
  - [8] RS (0 = instruction, 1 = data).
  - [9] long-wait flag.
  - [31] display power (ON).
  - Other bits are ignored.
- i_ovf_clr  in  1  clears the sticky overflow flag.
- o_lcd_data  out  8  LCD data bus.
- o_lcd_rs  out  1  LCD register select.
- o_lcd_rw  out  1  tied 0 (write only).
- o_lcd_en  out  1  LCD enable strobe.
- o_lcd_on  out  1  LCD power/backlight.
- o_busy  out  1  high while FSM is not IDLE or FIFO is not empty.
- o_full  out  1  FIFO count == FIFO_DEPTH.
- o_ovf  out  1  sticky: a write was dropped.

Behaviour:
- Reset:
  - Asserting i_reset low at any time forces FSM to IDLE and FIFO count to 0.
  - o_lcd_data = 0, o_lcd_rs = 0, o_lcd_en = 0, o_lcd_on = 0, o_busy = 0, o_full = 0, o_ovf = 0, all counters 0.
  - Reset in the middle of a pulse drops EN immediately (asynchronous). Buffered words are discarded.
- All outputs are registered, except o_busy and o_full, which decode registered state.
- FIFO write:
  - A word is accepted on the rising edge where i_lcd_wr = 1 and the pre-edge count < FIFO_DEPTH.
  - If the pre-edge count == FIFO_DEPTH, the word is dropped and o_ovf is set, even if a pop occurs on the same edge.
  - A simultaneous push and pop with count < DEPTH leaves the count unchanged. Ordering is FIFO, with wrap-around pointers.
- o_ovf:
  - Cleared by i_ovf_clr.
  - If set and clear happen on the same edge, set wins.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
- IDLE:
  - If count != 0, pop the head word on the edge.
  - On that edge: load o_lcd_data, o_lcd_rs and o_lcd_on from the word, latch the long flag, go to SETUP, and load the counter.
- SETUP: EN = 0 for T_SETUP cycles, then go to PULSE.
- PULSE: EN = 1 for exactly T_PULSE cycles, then go to HOLD.
- HOLD: EN = 0, data and RS unchanged, for T_HOLD cycles, then go to WAIT.
- WAIT:
  - Lasts T_WAIT cycles, or T_WAIT_LONG if the long flag is latched.
  - Then go to IDLE. A new pop may occur on the very next edge, so back-to-back commands have no extra gap.
- Latency:
  - The pop edge comes one edge after the write edge when the FIFO is empty and the FSM is idle.
  - From the pop edge, EN rises T_SETUP edges later and falls T_PULSE edges after that.
  - The FSM returns to IDLE T_SETUP + T_PULSE + T_HOLD + T_WAIT(_LONG) edges after the pop.
- o_lcd_data, o_lcd_rs and o_lcd_on hold their last values while IDLE.
- The counter is wide enough for max(T_WAIT_LONG, T_WAIT) and counts down to 1 before each transition.

Test Plan:
Bench parameters for all scenarios: T_SETUP = 2, T_PULSE = 4, T_HOLD = 2, T_WAIT = 10, T_WAIT_LONG = 50.

1. Single write 0x8000_0141 while idle:
   - At pop edge +1: o_lcd_data = 0x41, o_lcd_rs = 1, o_lcd_on = 1.
   - EN is high for exactly 4 cycles, starting 2 cycles after the pop.
   - o_busy falls 18 cycles after the pop.
2. Long command 0x8000_0201:
   - RS = 0, data = 0x01.
   - Return to IDLE 58 cycles after the pop.
3. Burst of 6 writes on consecutive cycles while idle:
   - The first is popped immediately, the next 4 fill the FIFO, the 6th is dropped.
   - o_full = 1 and o_ovf = 1.
   - Exactly 5 EN pulses are emitted in write order.
   - Pulses are spaced 18 cycles apart, EN rise to EN rise.
4. FIFO full, with i_lcd_wr high on the same edge the FSM pops:
   - The word is dropped and o_ovf is set.
   - Count goes 4 -> 3.
5. i_ovf_clr asserted alone:
   - o_ovf returns to 0 after the edge.
   - With i_ovf_clr asserted on the same edge as an overflowing write, o_ovf stays 1.
6. Reset asserted low during the 2nd PULSE cycle of a 3-deep queue:
   - EN = 0 immediately, all outputs 0.
   - After release, no EN pulse occurs and o_busy = 0.
